sync_debouncer: RTL and testbench

Debounces and edge-detects a single-bit signal that has already been brought into the `clk_i` domain by an `ff_syncer` instance placed directly upstream. A candidate new level is committed only after it has been sampled on a configured number of consecutive clock edges. On commit the block emits one-cycle rise/fall pulses and keeps a saturating count of rejected glitches for status registers. It drives button, strap and other slow external inputs into control logic.

---
 rtl/debounce_pkg.sv | 16 +
 rtl/sync_debouncer.sv | 123 ++++++++++++
 tb/tb_sync_debouncer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared types and helpers for the single-bit debouncer.
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LO,
        CHECK_HI,
        STABLE_HI,
        CHECK_LO
    } deb_state_t;

    // Width of the sample counter able to hold values up to cycles.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/sync_debouncer.sv
// Debounces an already-synchronized input, emits commit pulses and counts
// rejected transitions with a saturating, clearable counter.
module sync_debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter logic        RESET_VAL       = 1'b0,
    parameter int unsigned GLITCH_W        = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                data_i,
    input  logic                clr_glitch_i,
    output logic                level_o,
    output logic                rise_o,
    output logic                fall_o,
    output logic [GLITCH_W-1:0] glitch_cnt_o
);

    localparam int unsigned      CNT_W     = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam deb_state_t       RST_STATE = RESET_VAL ? STABLE_HI : STABLE_LO;

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce_cycles
        $error("sync_debouncer: DEBOUNCE_CYCLES must be at least 2");
    end

    deb_state_t          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                level_q, level_d;
    logic                rise_q, rise_d;
    logic                fall_q, fall_d;
    logic [GLITCH_W-1:0] glitch_q, glitch_d;
    logic                reject_c;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= RST_STATE;
            cnt_q    <= '0;
            level_q  <= RESET_VAL;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            glitch_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            glitch_q <= glitch_d;
        end
    end

    // A bounce-back is checked before the count so a bounce on the final sample rejects.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        level_d  = level_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        glitch_d = glitch_q;
        reject_c = 1'b0;

        case (state_q)
            STABLE_LO: begin
                if (data_i) begin
                    state_d = CHECK_HI;
                    cnt_d   = CNT_W'(1);
                end
            end
            CHECK_HI: begin
                if (!data_i) begin
                    state_d  = STABLE_LO;
                    cnt_d    = '0;
                    reject_c = 1'b1;
                end else if (cnt_q == LAST_CNT) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STABLE_HI: begin
                if (!data_i) begin
                    state_d = CHECK_LO;
                    cnt_d   = CNT_W'(1);
                end
            end
            CHECK_LO: begin
                if (data_i) begin
                    state_d  = STABLE_HI;
                    cnt_d    = '0;
                    reject_c = 1'b1;
                end else if (cnt_q == LAST_CNT) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = RST_STATE;
                cnt_d   = '0;
            end
        endcase

        if (clr_glitch_i) begin
            glitch_d = '0;
        end else if (reject_c && (glitch_q != '1)) begin
            glitch_d = glitch_q + GLITCH_W'(1);
        end
    end

    assign level_o      = level_q;
    assign rise_o       = rise_q;
    assign fall_o       = fall_q;
    assign glitch_cnt_o = glitch_q;

endmodule

// File: tb/tb_sync_debouncer.sv
// Directed and randomized checks of sync_debouncer against a run-length model.
module tb_sync_debouncer;

    localparam int unsigned DC   = 4;
    localparam int unsigned GW   = 2;
    localparam int unsigned GMAX = (1 << GW) - 1;

    logic          clk_i;
    logic          rst_i;
    logic          data_i;
    logic          clr_glitch_i;
    logic          level_o;
    logic          rise_o;
    logic          fall_o;
    logic [GW-1:0] glitch_cnt_o;

    int checks;
    int errors;

    // Reference: committed level, length of the current run of differing samples.
    logic m_level;
    int   m_run;
    int   m_glitch;
    logic m_rise;
    logic m_fall;

    sync_debouncer #(
        .DEBOUNCE_CYCLES(DC),
        .RESET_VAL      (1'b0),
        .GLITCH_W       (GW)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .data_i      (data_i),
        .clr_glitch_i(clr_glitch_i),
        .level_o     (level_o),
        .rise_o      (rise_o),
        .fall_o      (fall_o),
        .glitch_cnt_o(glitch_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_level  = 1'b0;
        m_run    = 0;
        m_glitch = 0;
        m_rise   = 1'b0;
        m_fall   = 1'b0;
    endtask

    task automatic model_sample(input logic d, input logic c);
        logic rej;
        rej    = 1'b0;
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (d != m_level) begin
            m_run++;
            if (m_run == int'(DC)) begin
                m_level = d;
                m_rise  = d;
                m_fall  = ~d;
                m_run   = 0;
            end
        end else begin
            rej   = (m_run > 0);
            m_run = 0;
        end
        if (c) m_glitch = 0;
        else if (rej && m_glitch < int'(GMAX)) m_glitch++;
    endtask

    // Apply one sample and compare every output against the model.
    task automatic step(input logic d, input logic c);
        data_i       = d;
        clr_glitch_i = c;
        @(posedge clk_i);
        #1;
        model_sample(d, c);
        chk("level", 32'(level_o), 32'(m_level));
        chk("rise", 32'(rise_o), 32'(m_rise));
        chk("fall", 32'(fall_o), 32'(m_fall));
        chk("glitch", 32'(glitch_cnt_o), 32'(m_glitch));
        chk("rise_fall_excl", 32'(rise_o & fall_o), 32'd0);
    endtask

    // Async reset in the high phase; outputs must clear before any clock edge.
    task automatic async_reset();
        #2 rst_i = 1'b1;
        #1;
        chk("arst_level", 32'(level_o), 32'd0);
        chk("arst_rise", 32'(rise_o), 32'd0);
        chk("arst_fall", 32'(fall_o), 32'd0);
        chk("arst_glitch", 32'(glitch_cnt_o), 32'd0);
        model_reset();
        #2 rst_i = 1'b0;
    endtask

    initial begin
        int unsigned v;
        int unsigned len;
        checks       = 0;
        errors       = 0;
        rst_i        = 1'b0;
        data_i       = 1'b0;
        clr_glitch_i = 1'b0;
        model_reset();

        #1 rst_i = 1'b1;
        #2;
        chk("init_level", 32'(level_o), 32'd0);
        chk("init_glitch", 32'(glitch_cnt_o), 32'd0);
        @(posedge clk_i);
        #1;
        #5 rst_i = 1'b0;

        // Back-to-back: rise on the 4th sample, fall on the 8th.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        chk("b2b_pre_rise", 32'(level_o), 32'd0);
        step(1'b1, 1'b0);
        chk("b2b_rise", 32'(rise_o), 32'd1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        chk("b2b_pre_fall", 32'(level_o), 32'd1);
        step(1'b0, 1'b0);
        chk("b2b_fall", 32'(fall_o), 32'd1);
        chk("b2b_glitch", 32'(glitch_cnt_o), 32'd0);

        // Short glitch, including a bounce on the final sample.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("glitch_one", 32'(glitch_cnt_o), 32'd1);
        chk("glitch_level", 32'(level_o), 32'd0);

        // Four more rejections saturate the counter, then clear wins over a rejection.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
        end
        chk("glitch_sat", 32'(glitch_cnt_o), 32'(GMAX));
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        chk("glitch_clr_prio", 32'(glitch_cnt_o), 32'd0);

        // Async reset while high with a nonzero glitch count and data_i high.
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        chk("pre_rst_level", 32'(level_o), 32'd1);
        async_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        chk("post_rst_hold", 32'(level_o), 32'd0);
        step(1'b1, 1'b0);
        chk("post_rst_commit", 32'(rise_o), 32'd1);

        // Reset mid-CHECK abandons the pending rise.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        async_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        chk("midchk_no_rise", 32'(rise_o), 32'd0);
        chk("midchk_glitch", 32'(glitch_cnt_o), 32'd0);
        step(1'b1, 1'b0);
        chk("midchk_commit", 32'(level_o), 32'd1);

        // Randomized runs of varying length with occasional clears.
        for (int s = 0; s < 80; s++) begin
            v   = $urandom_range(0, 1);
            len = $urandom_range(1, 6);
            for (int i = 0; i < int'(len); i++) begin
                step(v[0], ($urandom_range(0, 15) == 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
